ffo_seq_normalizer: RTL and testbench

//   Multi-cycle, parametrised find-first-one / normalizer for the fixed-point adder datapath.

---
 rtl/ffo_seq_normalizer.sv | 121 ++++++++++++
 tb/tb_ffo_seq_normalizer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/ffo_seq_normalizer.sv
// Multi-cycle leading-one finder / normalizer: scans the operand MSB-first, CHUNK bits per
// clock, and returns the leading-one index plus the operand shifted so that one lands at the MSB.
module ffo_seq_normalizer #(
    parameter  int WIDTH      = 32,
    parameter  int CHUNK      = 8,
    parameter  int EARLY_EXIT = 1,
    localparam int IDX_W      = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_found,
    output logic [IDX_W-1:0] out_index,
    output logic [WIDTH-1:0] out_norm
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int PW     = (CHUNK > 1) ? $clog2(CHUNK) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_sr;
    logic [CW-1:0]    r_cnt;
    logic             r_hit;
    logic             r_found;
    logic [IDX_W-1:0] r_index;
    logic [WIDTH-1:0] r_norm;

    logic [CHUNK-1:0] w_chunk;
    logic [PW-1:0]    w_p;
    logic             w_nz, w_last, w_hit, w_exit;
    logic [31:0]      w_pos;
    logic [IDX_W-1:0] w_index;
    logic [WIDTH-1:0] w_norm;

    assign w_chunk = r_sr[WIDTH-1 -: CHUNK];
    assign w_nz    = |w_chunk;
    assign w_last  = (r_cnt == CW'(NCHUNK - 1));
    assign w_hit   = w_nz && !r_hit;
    assign w_exit  = w_last || ((EARLY_EXIT != 0) && w_hit);

    // Ascending scan so the highest set bit wins; p counts down from the chunk MSB.
    always_comb begin
        w_p = '0;
        for (int i = 0; i < CHUNK; i++) begin
            if (w_chunk[i]) w_p = PW'(CHUNK - 1 - i);
        end
    end

    assign w_pos   = 32'(r_cnt) * 32'(CHUNK) + 32'(w_p);
    assign w_index = IDX_W'(32'(WIDTH - 1) - w_pos);
    // sr already carries the cnt*CHUNK shift, so only the in-chunk offset remains.
    assign w_norm  = r_sr << w_p;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_next = S_SCAN;
            S_SCAN:  if (w_exit) w_next = S_DONE;
            S_DONE:  if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = rst_n && (r_state == S_IDLE);
        out_valid = (r_state == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr    <= '0;
            r_cnt   <= '0;
            r_hit   <= 1'b0;
            r_found <= 1'b0;
            r_index <= '0;
            r_norm  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Results clear on accept so an all-zero operand reports found=0.
                    if (in_valid) begin
                        r_sr    <= in_data;
                        r_cnt   <= '0;
                        r_hit   <= 1'b0;
                        r_found <= 1'b0;
                        r_index <= '0;
                        r_norm  <= '0;
                    end
                end
                S_SCAN: begin
                    if (w_hit) begin
                        r_hit   <= 1'b1;
                        r_found <= 1'b1;
                        r_index <= w_index;
                        r_norm  <= w_norm;
                    end
                    if (!w_exit) begin
                        r_sr  <= r_sr << CHUNK;
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_found = r_found;
    assign out_index = r_index;
    assign out_norm  = r_norm;
endmodule

// File: tb/tb_ffo_seq_normalizer.sv
// Bench for ffo_seq_normalizer: four configurations run in lockstep against a
// count-leading-zeros reference model, plus back-pressure and reset-abort scenarios.
module tb_ffo_seq_normalizer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  iv, ordy, ir, ov, of;
    logic [31:0] d0, d1, n0, n1;
    logic [23:0] d2, n2;
    logic [15:0] d3, n3;
    logic [4:0]  x0, x1, x2;
    logic [3:0]  x3;

    int n_chk  = 0;
    int n_fail = 0;

    localparam int W [4] = '{32, 32, 24, 16};
    localparam int C [4] = '{8, 8, 4, 16};
    localparam int EE[4] = '{1, 0, 1, 1};

    always #5 clk = ~clk;

    ffo_seq_normalizer #(.WIDTH(32), .CHUNK(8), .EARLY_EXIT(1)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(d0),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_found(of[0]), .out_index(x0), .out_norm(n0));
    ffo_seq_normalizer #(.WIDTH(32), .CHUNK(8), .EARLY_EXIT(0)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(d1),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_found(of[1]), .out_index(x1), .out_norm(n1));
    ffo_seq_normalizer #(.WIDTH(24), .CHUNK(4), .EARLY_EXIT(1)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(d2),
        .out_valid(ov[2]), .out_ready(ordy[2]), .out_found(of[2]), .out_index(x2), .out_norm(n2));
    ffo_seq_normalizer #(.WIDTH(16), .CHUNK(16), .EARLY_EXIT(1)) u3 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir[3]), .in_data(d3),
        .out_valid(ov[3]), .out_ready(ordy[3]), .out_found(of[3]), .out_index(x3), .out_norm(n3));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Reference: count leading zeros, derive everything else arithmetically.
    task automatic model(input int w, input int ch, input int ee, input logic [31:0] d,
                         output logic f, output int idx, output logic [31:0] nrm, output int lat);
        int lz = 0;
        logic [63:0] t;
        logic [31:0] mask;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        while (lz < w && d[w-1-lz] == 1'b0) lz++;
        if (lz == w) begin
            f = 1'b0; idx = 0; nrm = '0; lat = w / ch;
        end else begin
            f   = 1'b1;
            idx = w - 1 - lz;
            t   = {32'b0, d} << lz;
            nrm = t[31:0] & mask;
            lat = (ee != 0) ? (lz / ch + 1) : (w / ch);
        end
    endtask

    task automatic wait_all_idle();
        int g = 0;
        while (ir != 4'hF && g < 50) begin
            @(posedge clk); #1; g++;
        end
        chk("idle_wait", 32'(ir), 32'hF);
    endtask

    task automatic xact(input logic [31:0] a, input logic [23:0] b, input logic [15:0] c);
        int          lat[4];
        logic        fnd[4];
        logic [31:0] ix[4], nm[4], din[4];
        logic        ef;
        int          ei, el;
        logic [31:0] en;
        int          e = 0;
        wait_all_idle();
        din = '{a, a, 32'(b), 32'(c)};
        d0 = a; d1 = a; d2 = b; d3 = c;
        iv = 4'hF; ordy = 4'hF;
        @(posedge clk); #1;
        iv = '0;
        d0 = $urandom; d1 = $urandom; d2 = 24'($urandom); d3 = 16'($urandom);
        lat = '{-1, -1, -1, -1};
        while ((lat[0] < 0 || lat[1] < 0 || lat[2] < 0 || lat[3] < 0) && e < 12) begin
            @(posedge clk); #1; e++;
            if (ov[0] && lat[0] < 0) begin lat[0] = e; fnd[0] = of[0]; ix[0] = 32'(x0); nm[0] = n0; end
            if (ov[1] && lat[1] < 0) begin lat[1] = e; fnd[1] = of[1]; ix[1] = 32'(x1); nm[1] = n1; end
            if (ov[2] && lat[2] < 0) begin lat[2] = e; fnd[2] = of[2]; ix[2] = 32'(x2); nm[2] = 32'(n2); end
            if (ov[3] && lat[3] < 0) begin lat[3] = e; fnd[3] = of[3]; ix[3] = 32'(x3); nm[3] = 32'(n3); end
        end
        for (int k = 0; k < 4; k++) begin
            model(W[k], C[k], EE[k], din[k], ef, ei, en, el);
            chk($sformatf("u%0d_lat d=%h", k, din[k]), 32'(lat[k]), 32'(el));
            if (lat[k] >= 0) begin
                chk($sformatf("u%0d_found d=%h", k, din[k]), 32'(fnd[k]), 32'(ef));
                chk($sformatf("u%0d_index d=%h", k, din[k]), ix[k], 32'(ei));
                chk($sformatf("u%0d_norm d=%h", k, din[k]), nm[k], en);
            end
        end
    endtask

    function automatic logic [31:0] rnd(input int w);
        logic [63:0] r;
        r = {32'b0, $urandom} >> (32 - w);
        r = r >> $urandom_range(0, w);
        return r[31:0];
    endfunction

    task automatic wait_ov0(output int e);
        e = 0;
        while (!ov[0] && e < 12) begin
            @(posedge clk); #1; e++;
        end
    endtask

    initial begin
        int          e;
        logic        seen;
        logic [31:0] w0;
        rst_n = 1'b0; iv = '0; ordy = 4'hF;
        d0 = '0; d1 = '0; d2 = '0; d3 = '0;
        #1;
        chk("rst_in_ready", 32'(ir), 32'h0);
        chk("rst_out_valid", 32'(ov), 32'h0);
        chk("rst_found", 32'(of), 32'h0);
        chk("rst_index", 32'(x0), 32'h0);
        chk("rst_norm", n0, 32'h0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1 chk("post_rst_in_ready", 32'(ir), 32'hF);

        // Directed corner values, walking one, all ones.
        xact(32'h8000_0000, 24'h80_0000, 16'h8000);
        xact(32'h0012_3456, 24'h01_2345, 16'h0123);
        xact(32'h0000_0001, 24'h00_0001, 16'h0001);
        xact(32'h0000_0000, 24'h00_0000, 16'h0000);
        for (int i = 0; i < 32; i++)
            xact(32'd1 << i, 24'd1 << (i % 24), 16'd1 << (i % 16));
        xact(32'hFFFF_FFFF, 24'hFF_FFFF, 16'hFFFF);

        // Back-pressure: result held, nothing new accepted, no bypass after handshake.
        wait_all_idle();
        d0 = 32'hA5A5_0000; iv = 4'b0001; ordy = 4'b0000;
        @(posedge clk); #1;
        iv = '0;
        wait_ov0(e);
        chk("bp_lat", 32'(e), 32'd1);
        for (int i = 0; i < 5; i++) begin
            iv[0] = 1'($urandom); d0 = $urandom;
            @(posedge clk); #1;
            chk("bp_out_valid", 32'(ov[0]), 32'h1);
            chk("bp_in_ready", 32'(ir[0]), 32'h0);
            chk("bp_found", 32'(of[0]), 32'h1);
            chk("bp_index", 32'(x0), 32'd31);
            chk("bp_norm", n0, 32'hA5A5_0000);
        end
        d0 = 32'h0000_0100; iv[0] = 1'b1; ordy = 4'hF;
        @(posedge clk); #1;
        chk("hs_out_valid_drop", 32'(ov[0]), 32'h0);
        chk("hs_no_bypass", 32'(ir[0]), 32'h1);
        @(posedge clk); #1;
        iv = '0;
        chk("next_accepted", 32'(ir[0]), 32'h0);
        wait_ov0(e);
        chk("next_lat", 32'(e), 32'd3);
        chk("next_index", 32'(x0), 32'd8);
        chk("next_norm", n0, 32'h8000_0000);
        @(posedge clk); #1;

        // Reset during SCAN aborts the operand.
        wait_all_idle();
        d0 = 32'h0000_00F0; iv = 4'b0001;
        @(posedge clk); #1;
        iv = '0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 32'(ov), 32'h0);
        chk("abort_in_ready", 32'(ir), 32'h0);
        chk("abort_found", 32'(of[0]), 32'h0);
        chk("abort_index", 32'(x0), 32'h0);
        chk("abort_norm", n0, 32'h0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            seen |= ov[0];
        end
        chk("abort_no_result", 32'(seen), 32'h0);
        chk("abort_idle", 32'(ir[0]), 32'h1);
        xact(32'h0000_0100, 24'h00_0100, 16'h0100);

        // Random operands with a random leading-one position.
        for (int i = 0; i < 2500; i++) begin
            w0 = rnd(32);
            xact(w0, 24'(rnd(24)), 16'(rnd(16)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
